// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared types and helpers for the bit-serial subtractor.
//               - state_t   : controller states (IDLE, RUN, DONE)
//               - cnt_width : bit-counter width for a given operand width
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must be able to represent WIDTH, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : Single-bit combinational full subtractor, d = a - b - bin.
// Ports       : a, b, bin (in)  - minuend bit, subtrahend bit, borrow-in
//               d, bout   (out) - difference bit, borrow-out
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when they are equal and a borrow
    // is already pending from the lower bit.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial subtractor, diff = a - b (mod 2^WIDTH), LSB first,
//               one bit per clock through a single full_subtractor cell.
// Ports       : clk, rst_n (async, active-low)
//               start, a, b          - request and operands (taken in IDLE)
//               busy, done           - handshake status (registered)
//               diff, borrow         - result and final borrow (registered)
//               ovf                  - signed overflow, only when the macro
//                                      SERIAL_SUB_OVF_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int                c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_bin;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_d;
    logic               w_bout;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    full_subtractor u_fs (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    // New bit enters at the MSB; after WIDTH shifts bit 0 of the operands
    // has landed in bit 0 of the result. Written as a shifted concatenation
    // so it stays legal for WIDTH=1.
    assign w_res_next = WIDTH'({w_d, r_res} >> 1);
    assign w_last     = (r_cnt == c_last);

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Status flops are loaded from the next state so they are
            // clean registers that line up with r_state.
            busy    <= (w_state_next == RUN);
            done    <= (w_state_next == DONE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_bin  <= 1'b0;
            r_cnt  <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_res <= '0;
                        r_bin <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_bin <= w_bout;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        diff   <= w_res_next;
                        borrow <= w_bout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand MSBs are consumed by the shifters, so keep a copy for the
    // overflow decision on the final bit (w_d is then the result MSB).
    logic [1:0] r_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msb <= 2'b00;
            ovf   <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_msb <= {a[WIDTH-1], b[WIDTH-1]};
            end
            if (r_state == RUN && w_last) begin
                ovf <= (r_msb[1] != r_msb[0]) && (w_d != r_msb[1]);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed self-checking bench for serial_subtractor, using a
//               WIDTH=8 instance and a WIDTH=1 instance on a shared clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, borrow;
    logic [7:0] diff;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1, done1, borrow1;
    logic [0:0] diff1;

`ifdef SERIAL_SUB_OVF_EN
    logic       ovf, ovf1;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int stable_err = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start1),
        .a      (a1),
        .b      (b1),
        .busy   (busy1),
        .done   (done1),
        .diff   (diff1),
        .borrow (borrow1)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf1)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One WIDTH=8 operation: start pulse, count busy cycles, check result.
    task automatic run8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] ed, input logic eb, input logic eo);
        int nb;
        int g;
        logic [7:0] hold;
        @(negedge clk);
        start = 1'b1; a = ia; b = ib;
        hold = diff;
        @(negedge clk);
        start = 1'b0; a = ~ia; b = ~ib;
        nb = 0; g = 0;
        while (done !== 1'b1 && g < 40) begin
            if (busy === 1'b1) nb++;
            if (diff !== hold) stable_err++;
            @(negedge clk);
            g++;
        end
        check({tag, " done_seen"}, 64'(g < 40), 64'd1);
        check({tag, " busy_cycles"}, 64'(nb), 64'd8);
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check({tag, " diff"}, 64'(diff), 64'(ed));
        check({tag, " borrow"}, 64'(borrow), 64'(eb));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, " ovf"}, 64'(ovf), 64'(eo));
`else
        if (eo === 1'bx) stable_err++;
`endif
        @(negedge clk);
        check({tag, " done_pulse_end"}, 64'({done, busy}), 64'd0);
    endtask

    task automatic run1(input logic ia, input logic ib, input logic ed,
                        input logic eb, input logic eo);
        int nb;
        int g;
        @(negedge clk);
        start1 = 1'b1; a1 = ia; b1 = ib;
        @(negedge clk);
        start1 = 1'b0; a1 = ~ia; b1 = ~ib;
        nb = 0; g = 0;
        while (done1 !== 1'b1 && g < 10) begin
            if (busy1 === 1'b1) nb++;
            @(negedge clk);
            g++;
        end
        check("w1 busy_cycles", 64'(nb), 64'd1);
        check("w1 diff", 64'(diff1), 64'(ed));
        check("w1 borrow", 64'(borrow1), 64'(eb));
`ifdef SERIAL_SUB_OVF_EN
        check("w1 ovf", 64'(ovf1), 64'(eo));
`else
        if (eo === 1'bx) stable_err++;
`endif
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] qa [3];
        logic [7:0] qb [3];
        logic [7:0] qd [3];
        logic [7:0] last_d;
        int k;
        int dk;
        int last_t;
        int quiet_err;

        // ---------------- reset state ----------------
        #2;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst diff", 64'(diff), 64'd0);
        check("rst borrow", 64'(borrow), 64'd0);
        check("rst w1 outs", 64'({busy1, done1, diff1, borrow1}), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst ovf", 64'(ovf), 64'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ---------------- directed operations ----------------
        run8("5A-3C", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
        run8("00-01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run8("FF-FF", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
        run8("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run8("7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // ---------------- start held high, operands churning ----------------
        qa = '{8'h33, 8'h10, 8'hC8};
        qb = '{8'h11, 8'h20, 8'h64};
        qd = '{8'h22, 8'hF0, 8'h64};
        last_d = diff;
        @(negedge clk);
        start = 1'b1; a = qa[0]; b = qb[0];
        k = 1; dk = 0; last_t = -1;
        for (int t = 1; t < 60 && dk < 3; t++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                check("held diff", 64'(diff), 64'(qd[dk]));
                if (dk > 0) check("held period", 64'(t - last_t), 64'd10);
                last_t = t;
                last_d = diff;
                dk++;
            end else if (diff !== last_d) begin
                stable_err++;
            end
            if (busy === 1'b0 && done === 1'b0 && k < 3) begin
                a = qa[k]; b = qb[k]; k++;
            end else begin
                a = 8'($urandom); b = 8'($urandom);
            end
        end
        start = 1'b0;
        check("held ops_done", 64'(dk), 64'd3);

        // ---------------- asynchronous reset in RUN cycle 4 ----------------
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'h5A; b = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid busy_before_rst", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst outs", 64'({busy, done, diff, borrow}), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("mid rst ovf", 64'(ovf), 64'd0);
`endif
        quiet_err = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) quiet_err++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || diff !== 8'h00) quiet_err++;
        end
        check("mid no_partial", 64'(quiet_err), 64'd0);
        run8("10-20", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);

        // ---------------- WIDTH=1 exhaustive ----------------
        for (int i = 0; i < 4; i++) begin
            logic ia;
            logic ib;
            ia = i[1];
            ib = i[0];
            run1(ia, ib, ia ^ ib, ~ia & ib, ~ia & ib);
        end

        check("diff stable between ops", 64'(stable_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
